// File: rtl/i2s_receiver_if.sv
// I2S receiver bus: serial WS/data in, parallel samples and status out.
// Optional slot-length error outputs appear when I2S_RX_ERR_EN is defined.
interface i2s_receiver_if #(
  parameter int SAMPLE_W = 12
);
  logic                word_select;
  logic                sound_bit_in;
  logic [SAMPLE_W-1:0] left_sample;
  logic [SAMPLE_W-1:0] right_sample;
  logic                left_valid;
  logic                right_valid;
  logic                synced;
`ifdef I2S_RX_ERR_EN
  logic                slot_err;
  logic [7:0]          err_count;

  modport master (
    output word_select, sound_bit_in,
    input  left_sample, right_sample, left_valid, right_valid, synced,
    input  slot_err, err_count
  );
  modport slave (
    input  word_select, sound_bit_in,
    output left_sample, right_sample, left_valid, right_valid, synced,
    output slot_err, err_count
  );
`else
  modport master (
    output word_select, sound_bit_in,
    input  left_sample, right_sample, left_valid, right_valid, synced
  );
  modport slave (
    input  word_select, sound_bit_in,
    output left_sample, right_sample, left_valid, right_valid, synced
  );
`endif
endinterface

// File: rtl/i2s_receiver.sv
// Serial-to-parallel I2S receiver in the s_clk bit-clock domain (1-bit WS delay).
// Define I2S_RX_ERR_EN to add slot-length checking (slot_err, err_count).
module i2s_receiver #(
  parameter int SAMPLE_W  = 12,
  parameter int SLOT_BITS = 13
) (
  input  logic          s_clk,
  input  logic          reset,
  i2s_receiver_if.slave bus
);
  localparam int                  CNT_W   = $clog2(SAMPLE_W + 64);
  localparam logic [CNT_W-1:0]    CNT_MAX = CNT_W'(SAMPLE_W + 63);
  localparam logic [SAMPLE_W-1:0] MSB     = {1'b1, {(SAMPLE_W-1){1'b0}}};

  typedef enum logic [1:0] {INIT, HUNT, RECV} state_e;

  state_e              state_q, state_d;
  logic                ws_q;
  logic [SAMPLE_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SAMPLE_W-1:0] left_q, left_d, right_q, right_d;
  logic                lv_q, lv_d, rv_q, rv_d;
  logic                synced_q, synced_d;

  logic                ws_edge;
  logic [SAMPLE_W-1:0] bit_mask;
  logic [SAMPLE_W-1:0] word;

  // INIT only primes ws_q, so a WS already high at reset release is no edge.
  assign ws_edge  = (state_q != INIT) && (bus.word_select != ws_q);
  // Mask runs off the LSB end once cnt_q >= SAMPLE_W, dropping long-slot bits.
  assign bit_mask = MSB >> cnt_q;
  assign word     = shift_q | (bus.sound_bit_in ? bit_mask : '0);

  always_ff @(posedge s_clk or negedge reset) begin
    if (!reset) begin
      state_q  <= INIT;
      ws_q     <= 1'b0;
      shift_q  <= '0;
      cnt_q    <= '0;
      left_q   <= '0;
      right_q  <= '0;
      lv_q     <= 1'b0;
      rv_q     <= 1'b0;
      synced_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ws_q     <= bus.word_select;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      left_q   <= left_d;
      right_q  <= right_d;
      lv_q     <= lv_d;
      rv_q     <= rv_d;
      synced_q <= synced_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    left_d   = left_q;
    right_d  = right_q;
    lv_d     = 1'b0;
    rv_d     = 1'b0;
    synced_d = synced_q;
    case (state_q)
      INIT: state_d = HUNT;
      HUNT: begin
        if (ws_edge) begin
          synced_d = 1'b1;
          shift_d  = '0;
          cnt_d    = '0;
          state_d  = RECV;
        end
      end
      RECV: begin
        if (ws_edge) begin
          // ws_q still holds the closing slot's channel.
          if (!ws_q) begin
            left_d = word;
            lv_d   = 1'b1;
          end else begin
            right_d = word;
            rv_d    = 1'b1;
          end
          shift_d = '0;
          cnt_d   = '0;
        end else begin
          shift_d = word;
          cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        end
      end
      default: state_d = INIT;
    endcase
  end

  assign bus.left_sample  = left_q;
  assign bus.right_sample = right_q;
  assign bus.left_valid   = lv_q;
  assign bus.right_valid  = rv_q;
  assign bus.synced       = synced_q;

`ifdef I2S_RX_ERR_EN
  logic       err_q, err_d;
  logic [7:0] ecnt_q, ecnt_d;
  logic       bad_len;

  // Closing slot length counts the edge-cycle bit, hence cnt_q + 1.
  assign bad_len = (int'(cnt_q) + 1) != SLOT_BITS;

  always_ff @(posedge s_clk or negedge reset) begin
    if (!reset) begin
      err_q  <= 1'b0;
      ecnt_q <= '0;
    end else begin
      err_q  <= err_d;
      ecnt_q <= ecnt_d;
    end
  end

  always_comb begin
    err_d  = 1'b0;
    ecnt_d = ecnt_q;
    if (state_q == RECV && ws_edge && bad_len) begin
      err_d  = 1'b1;
      ecnt_d = (ecnt_q == 8'hFF) ? ecnt_q : ecnt_q + 8'd1;
    end
  end

  assign bus.slot_err  = err_q;
  assign bus.err_count = ecnt_q;
`endif
endmodule

// File: tb/tb_i2s_receiver.sv
// Self-checking bench for i2s_receiver: slot-level reference model vs cycle checks.
module tb_i2s_receiver;
  localparam int SAMPLE_W  = 12;
  localparam int SLOT_BITS = 13;

  logic s_clk = 1'b0;
  logic reset = 1'b0;

  i2s_receiver_if #(.SAMPLE_W(SAMPLE_W)) bus();
  i2s_receiver #(.SAMPLE_W(SAMPLE_W), .SLOT_BITS(SLOT_BITS)) dut (
    .s_clk(s_clk), .reset(reset), .bus(bus)
  );

  always #5 s_clk = ~s_clk;

  typedef struct {
    bit          w;
    int          len;
    logic [63:0] data;
  } slot_t;

  slot_t               slots[$];
  int                  checks = 0;
  int                  errors = 0;
  int                  pulses;
  logic [SAMPLE_W-1:0] m_left, m_right;
  int                  m_errs;

  // Word a slot should yield: its first SAMPLE_W bits MSB-first, zero padded.
  function automatic logic [SAMPLE_W-1:0] slot_word(slot_t s);
    logic [SAMPLE_W-1:0] w = '0;
    for (int i = 0; i < s.len && i < SAMPLE_W; i++) w[SAMPLE_W-1-i] = s.data[s.len-1-i];
    return w;
  endfunction

  task automatic add_slot(input bit w, input int len, input logic [63:0] data);
    slot_t s;
    s.w = w; s.len = len; s.data = data;
    slots.push_back(s);
  endtask

  // Reset, then play: lead WS segment, queued slots, tail segment (never closed).
  task automatic drive_stream(input bit lead_w, input int lead_len, input int tail_len);
    bit ws_s[$];
    bit d_s[$];
    int close_at[$];
    int t, k;
    bit tail_w, e_lv, e_rv, e_err, e_sync;
    for (int i = 0; i < lead_len; i++) ws_s.push_back(lead_w);
    for (int i = 0; i <= lead_len; i++) d_s.push_back(bit'($urandom_range(1, 0)));
    t = lead_len;
    foreach (slots[j]) begin
      for (int i = 0; i < slots[j].len; i++) begin
        ws_s.push_back(slots[j].w);
        d_s.push_back(slots[j].data[slots[j].len-1-i]);
      end
      t += slots[j].len;
      close_at.push_back(t);
    end
    tail_w = (slots.size() > 0) ? !slots[slots.size()-1].w : !lead_w;
    for (int i = 0; i < tail_len; i++) ws_s.push_back(tail_w);
    for (int i = 0; i < tail_len - 1; i++) d_s.push_back(bit'($urandom_range(1, 0)));

    reset = 1'b0;
    bus.word_select  = lead_w;
    bus.sound_bit_in = 1'b0;
    repeat (2) @(posedge s_clk);
    @(negedge s_clk);
    m_left = '0; m_right = '0; m_errs = 0; pulses = 0;
    reset = 1'b1;
    k = 0;
    for (int c = 0; c < ws_s.size(); c++) begin
      bus.word_select  = ws_s[c];
      bus.sound_bit_in = d_s[c];
      @(posedge s_clk);
      @(negedge s_clk);
      e_lv = 1'b0; e_rv = 1'b0; e_err = 1'b0;
      e_sync = (c >= lead_len);
      if (k < close_at.size() && c == close_at[k]) begin
        if (slots[k].w) begin m_right = slot_word(slots[k]); e_rv = 1'b1; end
        else            begin m_left  = slot_word(slots[k]); e_lv = 1'b1; end
        if (slots[k].len != SLOT_BITS) begin
          e_err = 1'b1;
          if (m_errs < 255) m_errs++;
        end
        k++;
      end
      if (bus.left_valid || bus.right_valid) pulses++;
      checks++;
      if (bus.left_valid !== e_lv) begin
        errors++; $display("FAIL left_valid cyc=%0d got=%b exp=%b", c, bus.left_valid, e_lv);
      end
      checks++;
      if (bus.right_valid !== e_rv) begin
        errors++; $display("FAIL right_valid cyc=%0d got=%b exp=%b", c, bus.right_valid, e_rv);
      end
      checks++;
      if (bus.left_sample !== m_left) begin
        errors++; $display("FAIL left_sample cyc=%0d got=%h exp=%h", c, bus.left_sample, m_left);
      end
      checks++;
      if (bus.right_sample !== m_right) begin
        errors++; $display("FAIL right_sample cyc=%0d got=%h exp=%h", c, bus.right_sample, m_right);
      end
      checks++;
      if (bus.synced !== e_sync) begin
        errors++; $display("FAIL synced cyc=%0d got=%b exp=%b", c, bus.synced, e_sync);
      end
`ifdef I2S_RX_ERR_EN
      checks++;
      if (bus.slot_err !== e_err) begin
        errors++; $display("FAIL slot_err cyc=%0d got=%b exp=%b", c, bus.slot_err, e_err);
      end
      checks++;
      if (bus.err_count !== 8'(m_errs)) begin
        errors++; $display("FAIL err_count cyc=%0d got=%0d exp=%0d", c, bus.err_count, m_errs);
      end
`else
      if (e_err) t = t; // slot length only matters with error checking built in
`endif
    end
    slots.delete();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (4) begin
      @(negedge s_clk);
      bus.word_select  = bit'($urandom_range(1, 0));
      bus.sound_bit_in = bit'($urandom_range(1, 0));
    end
    @(negedge s_clk);
    checks++;
    if ({bus.left_sample, bus.right_sample, bus.left_valid, bus.right_valid, bus.synced} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got L=%h R=%h lv=%b rv=%b sy=%b exp all 0",
               bus.left_sample, bus.right_sample, bus.left_valid, bus.right_valid, bus.synced);
    end
`ifdef I2S_RX_ERR_EN
    checks++;
    if (bus.slot_err !== 1'b0 || bus.err_count !== 8'd0) begin
      errors++; $display("FAIL reset_err got err=%b cnt=%0d exp 0/0", bus.slot_err, bus.err_count);
    end
`endif
  endtask

  task automatic test_ws_high_at_release();
    add_slot(1'b0, 13, 64'($urandom));
    add_slot(1'b1, 13, 64'($urandom));
    drive_stream(1'b1, 9, 3);
  endtask

  task automatic test_standard_frame();
    add_slot(1'b0, 13, {51'd0, 12'hA5C, 1'b1});
    add_slot(1'b1, 13, {51'd0, 12'h3F1, 1'b0});
    add_slot(1'b0, 13, {51'd0, 12'hA5C, 1'b0});
    drive_stream(1'b1, 3, 2);
    checks++;
    if (bus.left_sample !== 12'hA5C || bus.right_sample !== 12'h3F1) begin
      errors++; $display("FAIL std_frame got L=%h R=%h exp L=a5c R=3f1", bus.left_sample, bus.right_sample);
    end
  endtask

  task automatic test_short_slot();
    add_slot(1'b0, 8, 64'hB3);
    add_slot(1'b1, 13, 64'($urandom));
    drive_stream(1'b1, 4, 2);
    checks++;
    if (bus.left_sample !== 12'hB30) begin
      errors++; $display("FAIL short_slot got=%h exp=b30", bus.left_sample);
    end
`ifdef I2S_RX_ERR_EN
    checks++;
    if (bus.err_count !== 8'd1) begin
      errors++; $display("FAIL short_slot_errcnt got=%0d exp=1", bus.err_count);
    end
`endif
  endtask

  task automatic test_long_slot();
    add_slot(1'b1, 20, 64'h7FF00);
    add_slot(1'b0, 13, 64'($urandom));
    drive_stream(1'b0, 3, 2);
    checks++;
    if (bus.right_sample !== 12'h7FF) begin
      errors++; $display("FAIL long_slot got=%h exp=7ff", bus.right_sample);
    end
`ifdef I2S_RX_ERR_EN
    checks++;
    if (bus.err_count !== 8'd1) begin
      errors++; $display("FAIL long_slot_errcnt got=%0d exp=1", bus.err_count);
    end
`endif
  endtask

  task automatic test_reset_mid_slot();
    add_slot(1'b0, 13, 64'h1FFF);
    add_slot(1'b1, 13, 64'h1FFF);
    drive_stream(1'b1, 3, 6);  // tail: edge cycle plus 5 left bits
    reset = 1'b0;
    #1;
    checks++;
    if ({bus.left_sample, bus.right_sample, bus.synced} !== '0) begin
      errors++; $display("FAIL mid_slot_reset got L=%h R=%h sy=%b exp 0", bus.left_sample, bus.right_sample, bus.synced);
    end
    add_slot(1'b0, 13, {51'd0, 12'h123, 1'b0});
    add_slot(1'b1, 13, {51'd0, 12'h456, 1'b0});
    drive_stream(1'b1, 4, 3);
    checks++;
    if (bus.left_sample !== 12'h123 || bus.right_sample !== 12'h456) begin
      errors++; $display("FAIL after_rehunt got L=%h R=%h exp 123/456", bus.left_sample, bus.right_sample);
    end
  endtask

  task automatic test_min_slot();
    add_slot(1'b0, 1, 64'h1);
    add_slot(1'b1, 1, 64'h1);
    add_slot(1'b0, 2, 64'h2);
    add_slot(1'b1, 13, 64'($urandom));
    drive_stream(1'b1, 2, 2);
  endtask

  task automatic test_random();
    bit w = bit'($urandom_range(1, 0));
    for (int i = 0; i < 40; i++) begin
      add_slot(w, $urandom_range(24, 1), {$urandom, $urandom});
      w = !w;
    end
    drive_stream(bit'($urandom_range(1, 0)), $urandom_range(5, 2), $urandom_range(4, 1));
  endtask

  task automatic test_err_saturation();
    for (int i = 0; i < 300; i++) add_slot(bit'(i % 2), 5, 64'($urandom));
    drive_stream(1'b1, 3, 2);
    checks++;
    if (pulses !== 300) begin
      errors++; $display("FAIL sat_pulses got=%0d exp=300", pulses);
    end
`ifdef I2S_RX_ERR_EN
    checks++;
    if (bus.err_count !== 8'd255) begin
      errors++; $display("FAIL sat_errcnt got=%0d exp=255", bus.err_count);
    end
`endif
  endtask

  initial begin
    bus.word_select  = 1'b0;
    bus.sound_bit_in = 1'b0;
    test_reset();
    test_ws_high_at_release();
    test_standard_frame();
    test_short_slot();
    test_long_slot();
    test_reset_mid_slot();
    test_min_slot();
    test_random();
    test_err_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
